// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first.
//
// Recovers bytes from an idle-high serial line. Each well-framed byte is shown
// on data and announced by a one-cycle valid strobe. A stop bit sampled low
// gives a one-cycle frame_err strobe and leaves data unchanged. After a framing
// error the receiver waits for the line to return high before it looks for
// another start bit. This stops a line held low from producing repeated errors
// or bytes.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate in bit/s
//   Derived:  CLKS_PER_BIT = CLK_FREQ/BAUD, HALF_BIT = CLKS_PER_BIT/2
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   rx_i         in   1  serial line, idle high, asynchronous to clk
//   data_o       out  8  last correctly framed byte, held until the next good byte
//   valid_o      out  1  one-cycle strobe: data_o updated this cycle
//   frame_err_o  out  1  one-cycle strobe: stop bit sampled low
//   busy_o       out  1  high whenever the receiver FSM is not idle
//   state_dbg    out  3  current FSM state encoding (state_t), for observation
//
// Handshake: valid_o/frame_err_o are fire-and-forget strobes with no ready.
// A consumer that misses valid_o loses that byte. data_o stays stable until
// the next good frame arrives.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic [2:0] state_dbg
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // A bit period this short leaves no room for mid-bit sampling.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_params
      $error("uart_rx: CLKS_PER_BIT (%0d) must be at least 4", CLKS_PER_BIT);
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle-high level, so leaving
  // reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_m;
  logic rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state,   state_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg,   shreg_n;

  // The stop-bit outcome is registered first. The visible strobes follow one
  // cycle later, so valid_o appears one cycle after the stop sample.
  logic ok_q,  ok_n;
  logic err_q, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      ok_q    <= ok_n;
      err_q   <= err_n;
    end
  end

  // Sample points: HALF_BIT cycles after entering START (mid start bit), then
  // every CLKS_PER_BIT cycles (mid data and stop bits).
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_ONE;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    ok_n      = 1'b0;
    err_n     = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = S_START;
        end
      end

      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = S_DATA;
            bit_idx_n = '0;
          end else begin
            // The line went high again before mid start bit. Treat it as a
            // glitch: return to IDLE with no strobe.
            state_n = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          // Shift right with the new bit entering at the MSB. After eight
          // bits the first (LSB) bit has reached bit 0.
          shreg_n = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            // Leaving at mid stop bit allows a start bit to follow at once.
            ok_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers. shreg cannot change in the cycle after ok_q is set,
  // because the FSM is then in IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= ok_q;
      frame_err_o <= err_q;
      if (ok_q) begin
        data_o <= shreg;
      end
    end
  end

  assign busy_o    = (state != S_IDLE);
  assign state_dbg = state;

endmodule
